// File: rtl/onewire_master.sv
// onewire_master: byte-level 1-Wire bus master that produces
// DS18B20-compatible reset/presence, write-slot and read-slot waveforms.
//
// Ports:
//   i_clk        system clock (24 MHz)
//   i_rst        synchronous active-high reset
//   i_cmd_valid  command request, taken when o_ready is high
//   i_cmd        00 reset/presence, 01 write byte, 10 read byte, 11 no-op
//   i_wr_data    byte to write, latched on accept
//   o_ready      idle (or finishing), can accept a command
//   o_done       one-cycle completion pulse
//   o_rd_data    last byte read
//   o_presence   result of last reset command (1 = device answered)
//   o_owr        1 = pull bus low, 0 = release
//   i_owr        raw bus level from the pad
module onewire_master #(
    parameter int US_DIV = 24,
    parameter int T_RSTL = 480,
    parameter int T_RSTH = 480,
    parameter int T_PDS  = 70,
    parameter int T_SLOT = 70,
    parameter int T_LOW1 = 6,
    parameter int T_LOW0 = 60,
    parameter int T_RDS  = 13
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_cmd_valid,
    input  logic [1:0] i_cmd,
    input  logic [7:0] i_wr_data,
    output logic       o_ready,
    output logic       o_done,
    output logic [7:0] o_rd_data,
    output logic       o_presence,
    output logic       o_owr,
    input  logic       i_owr
);

    localparam int TW = 15;

    localparam logic [TW-1:0] C_ONE  = TW'(1);
    localparam logic [TW-1:0] C_RSTL = TW'(T_RSTL * US_DIV);
    localparam logic [TW-1:0] C_RSTH = TW'(T_RSTH * US_DIV);
    localparam logic [TW-1:0] C_PDS  = TW'(T_PDS * US_DIV);
    localparam logic [TW-1:0] C_SLOT = TW'(T_SLOT * US_DIV);
    localparam logic [TW-1:0] C_LOW1 = TW'(T_LOW1 * US_DIV);
    localparam logic [TW-1:0] C_LOW0 = TW'(T_LOW0 * US_DIV);
    // Read sample point expressed relative to the SLOT_HIGH entry,
    // since the timer restarts when the read low pulse ends.
    localparam logic [TW-1:0] C_RDSH = TW'((T_RDS - T_LOW1) * US_DIV);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RST_LOW   = 3'd1;
    localparam logic [2:0] S_RST_HIGH  = 3'd2;
    localparam logic [2:0] S_SLOT_LOW  = 3'd3;
    localparam logic [2:0] S_SLOT_HIGH = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic [1:0] CMD_RST = 2'b00;
    localparam logic [1:0] CMD_WR  = 2'b01;
    localparam logic [1:0] CMD_RD  = 2'b10;

    // State registers
    logic [2:0]    r_state;
    logic [TW-1:0] r_tmr;
    logic [2:0]    r_idx;
    logic [1:0]    r_cmd;
    logic [7:0]    r_wbyte;
    logic [7:0]    r_rbyte;
    logic          r_owr;
    logic [7:0]    r_rd_data;
    logic          r_presence;
    logic          r_sync1;
    logic          r_sync2;

    // Next-state values
    logic [2:0]    w_state_nxt;
    logic [TW-1:0] w_tmr_nxt;
    logic [2:0]    w_idx_nxt;
    logic [1:0]    w_cmd_nxt;
    logic [7:0]    w_wbyte_nxt;
    logic [7:0]    w_rbyte_nxt;
    logic          w_owr_nxt;
    logic [7:0]    w_rd_nxt;
    logic          w_pres_nxt;

    // Decodes
    logic          w_ready;
    logic          w_accept;
    logic          w_bit;
    logic [TW-1:0] w_low_len;
    logic [TW-1:0] w_high_len;
    logic          w_rd_sample;
    logic          w_low_end;
    logic          w_high_end;

    assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_accept = i_cmd_valid && w_ready;

    // Write-0 slots hold the bus low for most of the slot; write-1
    // and read slots only give a short start pulse.
    assign w_bit      = r_wbyte[r_idx];
    assign w_low_len  = ((r_cmd == CMD_WR) && !w_bit) ? C_LOW0 : C_LOW1;
    assign w_high_len = C_SLOT - w_low_len;

    assign w_low_end   = (r_tmr == (w_low_len - C_ONE));
    assign w_high_end  = (r_tmr == (w_high_len - C_ONE));
    assign w_rd_sample = (r_cmd == CMD_RD) && (r_tmr == C_RDSH);

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr + C_ONE;
        w_idx_nxt   = r_idx;
        w_cmd_nxt   = r_cmd;
        w_wbyte_nxt = r_wbyte;
        w_rbyte_nxt = r_rbyte;
        w_owr_nxt   = r_owr;
        w_rd_nxt    = r_rd_data;
        w_pres_nxt  = r_presence;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = '0;
                w_owr_nxt   = 1'b0;
                if (w_accept) begin
                    w_cmd_nxt   = i_cmd;
                    w_wbyte_nxt = i_wr_data;
                    w_idx_nxt   = '0;
                    case (i_cmd)
                        CMD_RST: begin
                            w_state_nxt = S_RST_LOW;
                            w_owr_nxt   = 1'b1;
                        end
                        CMD_WR, CMD_RD: begin
                            w_state_nxt = S_SLOT_LOW;
                            w_owr_nxt   = 1'b1;
                            w_rbyte_nxt = '0;
                        end
                        default: begin
                            w_state_nxt = S_DONE;
                        end
                    endcase
                end
            end

            S_RST_LOW: begin
                if (r_tmr == (C_RSTL - C_ONE)) begin
                    w_state_nxt = S_RST_HIGH;
                    w_tmr_nxt   = '0;
                    w_owr_nxt   = 1'b0;
                end
            end

            S_RST_HIGH: begin
                if (r_tmr == C_PDS) begin
                    w_pres_nxt = !r_sync2;
                end
                if (r_tmr == (C_RSTH - C_ONE)) begin
                    w_state_nxt = S_DONE;
                    w_tmr_nxt   = '0;
                end
            end

            S_SLOT_LOW: begin
                if (w_low_end) begin
                    w_state_nxt = S_SLOT_HIGH;
                    w_tmr_nxt   = '0;
                    w_owr_nxt   = 1'b0;
                end
            end

            S_SLOT_HIGH: begin
                if (w_rd_sample) begin
                    w_rbyte_nxt[r_idx] = r_sync2;
                end
                if (w_high_end) begin
                    w_tmr_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_DONE;
                        if (r_cmd == CMD_RD) begin
                            w_rd_nxt = w_rbyte_nxt;
                        end
                    end else begin
                        w_idx_nxt   = r_idx + 3'd1;
                        w_state_nxt = S_SLOT_LOW;
                        w_owr_nxt   = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = '0;
                w_owr_nxt   = 1'b0;
            end
        endcase
    end

    // Bus input synchronizer
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_owr;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_idx      <= '0;
            r_cmd      <= '0;
            r_wbyte    <= '0;
            r_rbyte    <= '0;
            r_owr      <= 1'b0;
            r_rd_data  <= '0;
            r_presence <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tmr      <= w_tmr_nxt;
            r_idx      <= w_idx_nxt;
            r_cmd      <= w_cmd_nxt;
            r_wbyte    <= w_wbyte_nxt;
            r_rbyte    <= w_rbyte_nxt;
            r_owr      <= w_owr_nxt;
            r_rd_data  <= w_rd_nxt;
            r_presence <= w_pres_nxt;
        end
    end

    assign o_ready    = w_ready;
    assign o_done     = (r_state == S_DONE);
    assign o_owr      = r_owr;
    assign o_rd_data  = r_rd_data;
    assign o_presence = r_presence;

endmodule

// File: doc/onewire_master.md
# onewire_master

Byte-level 1-Wire bus master that generates DS18B20-compatible reset/presence, write-slot and read-slot waveforms. Sits directly below the temperature-reading controller (`read_temp`) and directly above the open-drain pad buffer: the controller issues reset/write-byte/read-byte commands, and this block drives `o_owr` to the pad's output-enable and samples `i_owr` from the pad. It runs from the 24 MHz `SB_HFOSC` clock.

## Interface
- `US_DIV`, 24: clock cycles per microsecond.
- `T_RSTL`, 480: reset low time, µs.
- `T_RSTH`, 480: release time after the reset pulse, µs.
- `T_PDS`, 70: presence sample point, µs after the reset release.
- `T_SLOT`, 70: full bit-slot length including recovery, µs.
- `T_LOW1`, 6: low time for write-1 and read slots, µs.
- `T_LOW0`, 60: low time for write-0 slots, µs.
- `T_RDS`, 13: read sample point, µs after the slot start.

Ports:
- `i_clk` in 1: system clock.
- `i_rst` in 1: synchronous, active-high reset.
- `i_cmd_valid` in 1: command request.
- `i_cmd` in 2: 00 = reset/presence, 01 = write byte, 10 = read byte, 11 = no-op.
- `i_wr_data` in 8: byte to write, captured on accept.
- `o_ready` out 1: idle, can accept a command.
- `o_done` out 1: one-cycle completion pulse.
- `o_rd_data` out 8: last byte read.
- `o_presence` out 1: result of the last reset command (1 = device answered).
- `o_owr` out 1: 1 = pull the bus low; 0 = release the bus (the pad drives the line low while this is 1).
- `i_owr` in 1: raw bus level from the pad.

## Operation
- Reset values: `o_ready`=1, `o_done`=0, `o_rd_data`=0x00, `o_presence`=0, `o_owr`=0, state IDLE, timer 0, bit index 0.
- `i_owr` passes through a 2-FF synchronizer; every sample uses the synchronized value.
- Accept: `i_cmd_valid & o_ready` at a rising edge. At accept, `i_cmd` and `i_wr_data` are latched and `o_ready` is 0 from the next cycle. `i_cmd_valid` is ignored while `o_ready` is 0.
- States: IDLE, RST_LOW, RST_HIGH, SLOT_LOW, SLOT_HIGH, DONE.
- A single cycle timer, at least 15 bits wide, reloads on every state entry and counts up.
- **Reset command:** IDLE → RST_LOW → RST_HIGH → DONE.
  - RST_LOW: `o_owr`=1 for `T_RSTL*US_DIV` cycles.
  - RST_HIGH: `o_owr`=0 for `T_RSTH*US_DIV` cycles.
  - At RST_HIGH cycle `T_PDS*US_DIV`, `o_presence` ← !sync_in.
- **Write byte:** 8 slots, LSB first, back to back. Each slot is `T_SLOT*US_DIV` cycles.
  - SLOT_LOW: `o_owr`=1 for `T_LOW1*US_DIV` cycles if the bit is 1, or `T_LOW0*US_DIV` cycles if the bit is 0.
  - SLOT_HIGH: `o_owr`=0 for the remainder of the slot.
- **Read byte:** 8 slots, LSB first.
  - SLOT_LOW lasts `T_LOW1*US_DIV` cycles.
  - At slot cycle `T_RDS*US_DIV` (counted from the slot start), sync_in is shifted into bit[i] of an internal shift register.
  - `o_rd_data` keeps its old value until DONE, where it is loaded with the assembled byte.
- **No-op (11):** IDLE → DONE with no bus activity. `o_presence` and `o_rd_data` are unchanged.
- DONE lasts one cycle: `o_done`=1, `o_ready`=1, then IDLE. A new command may be accepted in the DONE cycle.
- `i_rst` in any state: at the next edge, all outputs return to their reset values and `o_owr`=0 (bus released). An in-flight command is dropped with no `o_done`.

## Timing
- Accept at edge k: `o_owr` rises at k+1 (reset, write and read commands).
- Slot i starts at k+1+i·`T_SLOT*US_DIV`.
- Total bus phase length N, with DONE (`o_done`) at cycle k+1+N:
  - reset: N = (`T_RSTL`+`T_RSTH`)·`US_DIV` = 23040;
  - write or read: N = 8·`T_SLOT`·`US_DIV` = 13440;
  - no-op: `o_done` at k+1.
- The sample point includes the 2-cycle synchronizer delay. Input changes fewer than 2 cycles before the sample edge are not observed.
- `o_owr` is registered and glitch-free, with exactly one rising edge per slot.

## Test plan
- **Power-on:** hold `i_rst` for 3 cycles → `o_ready`=1, `o_owr`=0, `o_done`=0, `o_presence`=0, `o_rd_data`=0x00.
- **Reset with slave model:** slave pulls the line low 15–135 µs after release → `o_owr` high for exactly 11520 cycles, `o_presence`=1, `o_done` at accept+1+23040. Repeat with no slave → `o_presence`=0.
- **Write 0xA5:** low-pulse widths in order are 6, 60, 6, 60, 60, 6, 60, 6 µs (×24 cycles). Slot starts are spaced 1680 cycles apart. `o_done` at accept+13441.
- **Read:** slave model holds the line low through 45 µs for 0-bits, returning 0x3C → `o_rd_data`=0x3C on the `o_done` cycle, and 0x00 (unchanged) before it.
- **Busy and reset:**
  - Pulse `i_cmd_valid` mid-write → ignored, and only one `o_done` results.
  - Assert `i_rst` at write slot 3 during SLOT_LOW → `o_owr`=0 on the next edge, no `o_done`, `o_ready`=1.
- **Back-to-back:** issue a new command in the DONE cycle → it is accepted, and `o_owr` rises on the following cycle.
